// File: rtl/fetch_buffer_stage_pkg.sv
// Shared constants and types for the fetch front end. NOOP is the same word
// the decode-stage instruction register resets to, so an empty fetch buffer
// and a freshly reset decode stage both show the same bubble.
package fetch_buffer_stage_pkg;

  // Bubble instruction shown at the buffer head whenever nothing is buffered.
  localparam logic [31:0] NOOP = 32'h0000_0013;

  // Fetch defaults shared by the stage and anything that models it.
  localparam logic [31:0] DEFAULT_INST_SIZE = 32'd4;
  localparam logic [31:0] DEFAULT_START_PC  = 32'h0000_0040;
  localparam int          DEFAULT_DEPTH     = 4;
  localparam int          DEFAULT_PTR_BITS  = 2;

  // What the FIFO does at the next edge, encoded as {push, pop}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifoOp_t;

  // Folds the two handshake strobes into one operation code.
  function automatic fifoOp_t fifoOp(input logic push, input logic pop);
    return fifoOp_t'({push, pop});
  endfunction

endpackage

// File: rtl/fetch_buffer_stage_if.sv
// Bundle of the fetch stage's buses: the IMEM address/data pair, the
// execute-stage redirect, and the valid/ready head port toward decode.
// 'master' is the fetch stage itself; 'slave' is everything around it.
interface fetch_buffer_stage_if #(
  parameter int DBITS    = 32,
  parameter int PTR_BITS = 2
);

  // Instruction memory side.
  logic [DBITS-1:0] pcOut;
  logic [DBITS-1:0] iMemOut;

  // Execute-stage redirect.
  logic             redirectEn;
  logic [DBITS-1:0] redirectPc;

  // Decode-side head port.
  logic             outValid;
  logic             outReady;
  logic [DBITS-1:0] outInstr;
  logic [DBITS-1:0] outPc;
  logic [PTR_BITS:0] occupancy;

  modport master (
    input  iMemOut,
    input  redirectEn,
    input  redirectPc,
    input  outReady,
    output pcOut,
    output outValid,
    output outInstr,
    output outPc,
    output occupancy
  );

  modport slave (
    output iMemOut,
    output redirectEn,
    output redirectPc,
    output outReady,
    input  pcOut,
    input  outValid,
    input  outInstr,
    input  outPc,
    input  occupancy
  );

endinterface

// File: rtl/fetch_buffer_stage_fifo.sv
// DEPTH-entry synchronous FIFO holding packed {pc, instr} words for the fetch
// stage. Flush empties it in one edge; the head is a combinational read of
// the entry under the read pointer, so a word written at edge N is first
// visible at the head in cycle N+1.
module fetch_fifo
  import fetch_buffer_stage_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int PTR_BITS = DEFAULT_PTR_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WIDTH-1:0]  pushData,
  output logic [WIDTH-1:0]  headData,
  output logic [PTR_BITS:0] count,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] rdPtr;
  logic [PTR_BITS-1:0] wrPtr;
  logic                doPush;
  logic                doPop;
  fifoOp_t             op;

  // Qualify the strobes: flush beats both, and the FIFO never over- or
  // under-runs even if the caller asks it to.
  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    doPush = 1'b0;
    doPop  = 1'b0;
    if (!flush) begin
      doPop  = pop & ~empty;
      doPush = push & (~full | doPop);
    end
    op = fifoOp(doPush, doPop);
  end

  // Pointers and count; both pointers wrap naturally modulo DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_BITS'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_BITS'(1);
      case (op)
        FIFO_PUSH: count <= count + (PTR_BITS + 1)'(1);
        FIFO_POP:  count <= count - (PTR_BITS + 1)'(1);
        default:   count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array is deliberately not reset; count gates every read, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign headData = mem[rdPtr];
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/fetch_buffer_stage.sv
// Fetch front end: owns the PC, presents it to instruction memory, captures
// each {pc, instruction} pair into a small FIFO, and hands the FIFO head to
// decode over valid/ready. A taken branch or jump from execute flushes the
// buffer and restarts fetch at the target on the following cycle.
module fetch_buffer_stage
  import fetch_buffer_stage_pkg::*;
#(
  parameter int               DBITS     = 32,
  parameter logic [DBITS-1:0] INST_SIZE = DBITS'(DEFAULT_INST_SIZE),
  parameter logic [DBITS-1:0] START_PC  = DBITS'(DEFAULT_START_PC),
  // DEPTH must be a power of two (at least 2) and equal 2**PTR_BITS, since
  // the FIFO pointers rely on natural wrap.
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter int               PTR_BITS  = DEFAULT_PTR_BITS
) (
  input logic                 clk,
  input logic                 reset,
  fetch_buffer_stage_if.master bus
);

  localparam int ENTRY_BITS = 2 * DBITS;

  logic [DBITS-1:0]      pcReg;
  logic [ENTRY_BITS-1:0] headData;
  logic [PTR_BITS:0]     count;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  pop;
  logic                  push;

  // Handshake arbitration. A fetch is captured whenever there is room, or
  // when the head leaves in the same cycle. outReady only reaches the FIFO
  // and the PC enable, never pcOut combinationally.
  always_comb begin
    pop  = ~fifoEmpty & bus.outReady;
    push = ~fifoFull | pop;
  end

  // PC register: reset beats redirect, redirect beats a sequential step;
  // when full with no pop the same PC is presented again.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg <= START_PC;
    end else if (bus.redirectEn) begin
      pcReg <= bus.redirectPc;
    end else if (push) begin
      pcReg <= pcReg + INST_SIZE;
    end
  end

  // Redirect acts as flush, which inside the FIFO overrides push and pop,
  // so the IMEM word fetched on the redirect cycle is dropped.
  fetch_fifo #(
    .WIDTH    (ENTRY_BITS),
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirectEn),
    .pushData ({pcReg, bus.iMemOut}),
    .headData (headData),
    .count    (count),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Head outputs, with NOOP/0 substituted while the buffer is empty.
  always_comb begin
    bus.pcOut     = pcReg;
    bus.occupancy = count;
    bus.outValid  = ~fifoEmpty;
    bus.outInstr  = DBITS'(NOOP);
    bus.outPc     = '0;
    if (!fifoEmpty) begin
      bus.outPc    = headData[ENTRY_BITS-1 -: DBITS];
      bus.outInstr = headData[DBITS-1:0];
    end
  end

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Bench for fetch_buffer_stage: a hand-derived vector table for the fill,
// full, flush, reset-priority and PC-wrap sequences, then a scoreboard-backed
// 100-cycle streaming run and a randomized run.
module tb_fetch_buffer_stage;
  import fetch_buffer_stage_pkg::*;

  localparam int          DBITS     = 32;
  localparam int          DEPTH     = 4;
  localparam int          PTR_BITS  = 2;
  localparam logic [31:0] START_PC  = 32'h40;
  localparam logic [31:0] INST_SIZE = 32'd4;
  localparam logic [31:0] BUBBLE    = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_buffer_stage_if #(.DBITS(DBITS), .PTR_BITS(PTR_BITS)) bus ();

  fetch_buffer_stage #(
    .DBITS     (DBITS),
    .INST_SIZE (INST_SIZE),
    .START_PC  (START_PC),
    .DEPTH     (DEPTH),
    .PTR_BITS  (PTR_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: a PC-derived pattern, returned in the same cycle.
  function automatic logic [31:0] imemWord(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.iMemOut = imemWord(bus.pcOut);

  int tests    = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic re, input logic [31:0] rpc, input logic rdy);
    reset          = r;
    bus.redirectEn = re;
    bus.redirectPc = rpc;
    bus.outReady   = rdy;
  endtask

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] expPc;
    logic [31:0] expOcc;
    logic        expValid;
    logic [31:0] expOutPc;
  } vec_t;

  vec_t vecs[28];

  // Reference model / scoreboard: expected PCs are queued when a fetch is
  // accepted and popped when decode takes the head.
  logic [31:0] mPc;
  logic [31:0] mQ[$];

  task automatic scoreCheck(input string tag, input int cyc);
    check($sformatf("%s pcOut c%0d", tag, cyc), bus.pcOut, mPc);
    check($sformatf("%s occupancy c%0d", tag, cyc), 32'(bus.occupancy), 32'(mQ.size()));
    check($sformatf("%s outValid c%0d", tag, cyc), 32'(bus.outValid), 32'(mQ.size() > 0));
    if (mQ.size() > 0) begin
      check($sformatf("%s outPc c%0d", tag, cyc), bus.outPc, mQ[0]);
      check($sformatf("%s outInstr c%0d", tag, cyc), bus.outInstr, imemWord(mQ[0]));
    end else begin
      check($sformatf("%s outPc c%0d", tag, cyc), bus.outPc, 32'h0);
      check($sformatf("%s outInstr c%0d", tag, cyc), bus.outInstr, BUBBLE);
    end
  endtask

  task automatic modelStep(input logic r, input logic re, input logic [31:0] rpc, input logic rdy);
    bit doPop;
    bit doPush;
    if (r) begin
      mPc = START_PC;
      mQ.delete();
    end else if (re) begin
      mPc = rpc;
      mQ.delete();
    end else begin
      doPop  = (mQ.size() > 0) && rdy;
      doPush = (mQ.size() < DEPTH) || doPop;
      if (doPop) void'(mQ.pop_front());
      if (doPush) begin
        mQ.push_back(mPc);
        mPc = mPc + INST_SIZE;
      end
    end
  endtask

  initial begin
    int gaps;
    logic r, re, rdy;
    logic [31:0] rpc;

    // {reset, redirectEn, redirectPc, outReady} -> {pcOut, occupancy, outValid, outPc}
    // Expected values describe the cycle in which the inputs are applied.
    vecs = '{
      // fill from reset with decode stalled
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h40,       32'd0, 1'b0, 32'h0},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h44,       32'd1, 1'b1, 32'h40},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h48,       32'd2, 1'b1, 32'h40},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h4C,       32'd3, 1'b1, 32'h40},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h50,       32'd4, 1'b1, 32'h40},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h50,       32'd4, 1'b1, 32'h40},
      // full with decode draining: push and pop together
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h50,       32'd4, 1'b1, 32'h40},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h54,       32'd4, 1'b1, 32'h44},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h58,       32'd4, 1'b1, 32'h48},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h5C,       32'd4, 1'b1, 32'h4C},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h60,       32'd4, 1'b1, 32'h50},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h64,       32'd4, 1'b1, 32'h54},
      // reset and redirect together while full: reset wins
      '{1'b1, 1'b1, 32'h123,      1'b0, 32'h64,       32'd4, 1'b1, 32'h54},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h40,       32'd0, 1'b0, 32'h0},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h44,       32'd1, 1'b1, 32'h40},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h48,       32'd2, 1'b1, 32'h40},
      // redirect with three entries buffered
      '{1'b0, 1'b1, 32'h200,      1'b0, 32'h4C,       32'd3, 1'b1, 32'h40},
      '{1'b0, 1'b0, 32'h0,        1'b0, 32'h200,      32'd0, 1'b0, 32'h0},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h204,      32'd1, 1'b1, 32'h200},
      // back-to-back redirects: last target wins
      '{1'b0, 1'b1, 32'h100,      1'b1, 32'h208,      32'd1, 1'b1, 32'h204},
      '{1'b0, 1'b1, 32'h300,      1'b1, 32'h100,      32'd0, 1'b0, 32'h0},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h300,      32'd0, 1'b0, 32'h0},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h304,      32'd1, 1'b1, 32'h300},
      // PC wraps through zero
      '{1'b0, 1'b1, 32'hFFFFFFF8, 1'b1, 32'h308,      32'd1, 1'b1, 32'h304},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFF8, 32'd0, 1'b0, 32'h0},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'd1, 1'b1, 32'hFFFFFFF8},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'd1, 1'b1, 32'hFFFFFFFC},
      '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        32'd1, 1'b1, 32'h0}
    };

    drive(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("vec%0d pcOut", i), bus.pcOut, vecs[i].expPc);
      check($sformatf("vec%0d occupancy", i), 32'(bus.occupancy), vecs[i].expOcc);
      check($sformatf("vec%0d outValid", i), 32'(bus.outValid), 32'(vecs[i].expValid));
      check($sformatf("vec%0d outPc", i), bus.outPc, vecs[i].expOutPc);
      check($sformatf("vec%0d outInstr", i), bus.outInstr,
            vecs[i].expValid ? imemWord(vecs[i].expOutPc) : BUBBLE);
      @(posedge clk);
      #1;
    end

    // Streaming from reset with decode always ready: no gaps after cycle 0.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    mPc = START_PC;
    mQ.delete();
    gaps = 0;
    for (int c = 0; c < 100; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      scoreCheck("stream", c);
      if (c > 0 && !bus.outValid) gaps++;
      modelStep(1'b0, 1'b0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
    end
    check("stream gaps", 32'(gaps), 32'd0);

    // Random stalls, redirects (including while full/empty) and resets.
    for (int c = 0; c < 300; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      re  = ($urandom_range(0, 11) == 0);
      rpc = 32'($urandom_range(0, 1023)) << 2;
      rdy = ($urandom_range(0, 2) != 0);
      drive(r, re, rpc, rdy);
      @(negedge clk);
      scoreCheck("rand", c);
      modelStep(r, re, rpc, rdy);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
